// File: rtl/sha256_msg_padder_if.sv
// rtl/sha256_msg_padder_if.sv - byte-in / padded-word-out handshake bundle for sha256_msg_padder
interface sha256_msg_padder_if;
  logic [7:0]  DIN;
  logic        DIN_VALID;
  logic        DIN_LAST;
  logic        DIN_READY;
  logic [31:0] W_OUT;
  logic [5:0]  I;
  logic        W_VALID;
  logic        W_READY;
  logic        FIRST;
  logic        FINAL;
  logic        DONE;

  modport master (
    input  DIN, DIN_VALID, DIN_LAST, W_READY,
    output DIN_READY, W_OUT, I, W_VALID, FIRST, FINAL, DONE
  );

  modport slave (
    output DIN, DIN_VALID, DIN_LAST, W_READY,
    input  DIN_READY, W_OUT, I, W_VALID, FIRST, FINAL, DONE
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - packs a byte stream into SHA-256 padded big-endian words
module sha256_msg_padder #(
  parameter int CNT_W = 32
) (
  input  logic               CLK,
  input  logic               RESET,
  sha256_msg_padder_if.master bus
);

  // Each state other than COLLECT names the word currently presented on W_OUT.
  typedef enum logic [2:0] {
    COLLECT, EMIT_DATA, EMIT_TAIL, EMIT_MARK, ZERO, LEN_HI, LEN_LO
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] byte_cnt;
  logic [1:0]       p;
  logic [23:0]      word_buf;
  logic [31:0]      w_out;
  logic [3:0]       idx;
  logic             w_valid;
  logic             first_r;
  logic             final_r;
  logic             done_r;
  logic             extra;
  logic             first_pending;
  logic             mark_pending;

  logic        din_ready;
  logic        byte_xfer;
  logic        word_xfer;
  logic [3:0]  idx_nx;
  logic        extra_nx;
  logic        pad_len;
  logic [63:0] bit_len;
  logic [31:0] data_word;
  logic [31:0] tail_word;

  assign din_ready = (state == COLLECT) && !w_valid;
  assign byte_xfer = bus.DIN_VALID && din_ready;
  assign word_xfer = w_valid && bus.W_READY;
  assign idx_nx    = idx + 4'd1;
  assign extra_nx  = extra && (idx != 4'd15);
  assign pad_len   = !extra_nx && (idx_nx == 4'd14);
  assign bit_len   = {{(61-CNT_W){1'b0}}, byte_cnt, 3'b000};

  // tail_word carries the 0x80 marker right after the last byte when it fits.
  always_comb begin
    data_word = {bus.DIN, 24'h000000};
    tail_word = {bus.DIN, 24'h800000};
    case (p)
      2'd1: begin
        data_word = {word_buf[23:16], bus.DIN, 16'h0000};
        tail_word = {word_buf[23:16], bus.DIN, 16'h8000};
      end
      2'd2: begin
        data_word = {word_buf[23:8], bus.DIN, 8'h00};
        tail_word = {word_buf[23:8], bus.DIN, 8'h80};
      end
      2'd3: begin
        data_word = {word_buf, bus.DIN};
        tail_word = {word_buf, bus.DIN};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= COLLECT;
      byte_cnt      <= '0;
      p             <= 2'd0;
      word_buf      <= 24'h0;
      w_out         <= 32'h0;
      idx           <= 4'd0;
      w_valid       <= 1'b0;
      first_r       <= 1'b0;
      final_r       <= 1'b0;
      done_r        <= 1'b0;
      extra         <= 1'b0;
      first_pending <= 1'b1;
      mark_pending  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        COLLECT: begin
          if (byte_xfer) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            word_buf <= data_word[31:8];
            if (bus.DIN_LAST) begin
              w_out        <= tail_word;
              w_valid      <= 1'b1;
              first_r      <= first_pending;
              p            <= 2'd0;
              mark_pending <= (p == 2'd3);
              extra        <= (p != 2'd3) && (idx >= 4'd14);
              state        <= EMIT_TAIL;
            end else if (p == 2'd3) begin
              w_out   <= data_word;
              w_valid <= 1'b1;
              first_r <= first_pending;
              p       <= 2'd0;
              state   <= EMIT_DATA;
            end else begin
              p <= p + 2'd1;
            end
          end
        end
        EMIT_DATA: begin
          if (word_xfer) begin
            w_valid       <= 1'b0;
            first_r       <= 1'b0;
            first_pending <= 1'b0;
            idx           <= idx_nx;
            state         <= COLLECT;
          end
        end
        EMIT_TAIL: begin
          if (word_xfer) begin
            first_r       <= 1'b0;
            first_pending <= 1'b0;
            idx           <= idx_nx;
            if (mark_pending) begin
              w_out <= 32'h8000_0000;
              extra <= (idx_nx >= 4'd14);
              state <= EMIT_MARK;
            end else begin
              extra <= extra_nx;
              w_out <= pad_len ? bit_len[63:32] : 32'h0;
              state <= pad_len ? LEN_HI : ZERO;
            end
          end
        end
        EMIT_MARK, ZERO: begin
          if (word_xfer) begin
            idx   <= idx_nx;
            extra <= extra_nx;
            w_out <= pad_len ? bit_len[63:32] : 32'h0;
            state <= pad_len ? LEN_HI : ZERO;
          end
        end
        LEN_HI: begin
          if (word_xfer) begin
            idx     <= idx_nx;
            w_out   <= bit_len[31:0];
            final_r <= 1'b1;
            state   <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (word_xfer) begin
            w_valid       <= 1'b0;
            final_r       <= 1'b0;
            done_r        <= 1'b1;
            idx           <= 4'd0;
            byte_cnt      <= '0;
            p             <= 2'd0;
            extra         <= 1'b0;
            first_pending <= 1'b1;
            state         <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.DIN_READY = din_ready;
  assign bus.W_OUT     = w_out;
  assign bus.I         = {2'b00, idx};
  assign bus.W_VALID   = w_valid;
  assign bus.FIRST     = first_r;
  assign bus.FINAL     = final_r;
  assign bus.DONE      = done_r;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - scoreboard bench for sha256_msg_padder
module tb_sha256_msg_padder;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  sha256_msg_padder_if bus();

  sha256_msg_padder #(.CNT_W(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.master)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] w;
    logic [5:0]  i;
    logic        first;
    logic        fin;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   rdy_mode = 1;
  bit   done_next = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference FIPS 180-4 padding built byte-wise, then split into indexed words.
  task automatic push_expected(input byte unsigned m[$]);
    byte unsigned     pb[$];
    longint unsigned  bits;
    int               nw;
    exp_t             e;
    pb = m;
    bits = 64'(m.size()) * 64'd8;
    pb.push_back(8'h80);
    while ((pb.size() % 64) != 56) pb.push_back(8'h00);
    for (int k = 7; k >= 0; k--) pb.push_back(8'(bits >> (8 * k)));
    nw = pb.size() / 4;
    for (int n = 0; n < nw; n++) begin
      e.w     = {pb[4*n], pb[4*n+1], pb[4*n+2], pb[4*n+3]};
      e.i     = 6'(n % 16);
      e.first = (n == 0);
      e.fin   = (n == nw - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send_msg(input byte unsigned m[$], input bit with_last);
    bit rdy;
    int guard;
    for (int k = 0; k < m.size(); k++) begin
      bus.DIN       = m[k];
      bus.DIN_VALID = 1'b1;
      bus.DIN_LAST  = with_last && (k == m.size() - 1);
      guard = 0;
      do begin
        @(negedge CLK);
        rdy = bus.DIN_READY;
        @(posedge CLK);
        #1;
        guard++;
      end while (!rdy && guard < 2000);
      if (!rdy) chk("din_ready_timeout", 64'(rdy), 64'd1);
    end
    bus.DIN_VALID = 1'b0;
    bus.DIN_LAST  = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((sb.size() != 0 || done_next) && g < 5000) begin
      @(posedge CLK);
      g++;
    end
    chk("drain", 64'(sb.size() == 0 && !done_next), 64'd1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bus.W_READY = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        0:       bus.W_READY = 1'b0;
        1:       bus.W_READY = 1'b1;
        default: bus.W_READY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        if (done_next || bus.DONE) chk("done", 64'(bus.DONE), 64'(done_next));
        done_next = 1'b0;
        if (bus.W_VALID && bus.W_READY) begin
          if (sb.size() == 0) begin
            chk("spurious_word", 64'(bus.W_VALID), 64'd0);
          end else begin
            e = sb.pop_front();
            chk("w_out", 64'(bus.W_OUT), 64'(e.w));
            chk("i",     64'(bus.I),     64'(e.i));
            chk("first", 64'(bus.FIRST), 64'(e.first));
            chk("final", 64'(bus.FINAL), 64'(e.fin));
            done_next = e.fin;
          end
        end
      end
    end
  end

  initial begin
    byte unsigned q[$];
    int lens[11];
    lens = '{1, 2, 5, 54, 57, 63, 64, 65, 119, 120, 121};
    bus.DIN = 8'h00;
    bus.DIN_VALID = 1'b0;
    bus.DIN_LAST = 1'b0;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("rst_w_valid",   64'(bus.W_VALID),   64'd0);
    chk("rst_i",         64'(bus.I),         64'd0);
    chk("rst_w_out",     64'(bus.W_OUT),     64'd0);
    chk("rst_first",     64'(bus.FIRST),     64'd0);
    chk("rst_final",     64'(bus.FINAL),     64'd0);
    chk("rst_done",      64'(bus.DONE),      64'd0);
    chk("rst_din_ready", 64'(bus.DIN_READY), 64'd1);
    @(posedge CLK);
    #1;

    q = '{8'h61, 8'h62, 8'h63};
    push_expected(q);
    send_msg(q, 1'b1);
    wait_drain();

    q = '{8'h61, 8'h62, 8'h63, 8'h64};
    push_expected(q);
    send_msg(q, 1'b1);
    wait_drain();

    q.delete();
    for (int k = 0; k < 55; k++) q.push_back(8'h00);
    push_expected(q);
    send_msg(q, 1'b1);
    wait_drain();

    q.push_back(8'h00);
    push_expected(q);
    send_msg(q, 1'b1);
    wait_drain();

    rdy_mode = 0;
    @(posedge CLK);
    #2;
    q = '{8'h61, 8'h62, 8'h63, 8'h64};
    push_expected(q);
    send_msg(q, 1'b1);
    repeat (5) begin
      @(negedge CLK);
      chk("bp_w_valid",   64'(bus.W_VALID),   64'd1);
      chk("bp_w_out",     64'(bus.W_OUT),     64'h61626364);
      chk("bp_i",         64'(bus.I),         64'd0);
      chk("bp_din_ready", 64'(bus.DIN_READY), 64'd0);
    end
    rdy_mode = 1;
    wait_drain();

    q = '{8'h11, 8'h22};
    send_msg(q, 1'b0);
    RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("abort_w_valid",   64'(bus.W_VALID),   64'd0);
    chk("abort_din_ready", 64'(bus.DIN_READY), 64'd1);
    @(posedge CLK);
    #1;
    q = '{8'h61, 8'h62, 8'h63};
    push_expected(q);
    send_msg(q, 1'b1);
    wait_drain();

    rdy_mode = 2;
    foreach (lens[n]) begin
      q.delete();
      for (int k = 0; k < lens[n]; k++) q.push_back(8'($urandom));
      push_expected(q);
      send_msg(q, 1'b1);
      wait_drain();
    end
    rdy_mode = 1;
    repeat (4) @(posedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
Producer side of the compressor's message-word interface. The block accepts a raw message as a byte stream and emits the SHA-256 padded message as 32-bit big-endian words, 16 per 512-bit block, each tagged with its word index I.
- Padding follows FIPS 180-4: a 0x80 marker, zero fill, then the 64-bit message bit length.
- The output feeds the W_IN/I input of the message-schedule/compressor path through a valid/ready handshake.

Parameters:
CNT_W, 32, width of the internal byte counter. Maximum message length is 2^CNT_W-1 bytes. Bit length is {byte_cnt,3'b000}, zero-extended to 64 bits.

Ports:
CLK  in  1  clock; all state updates on posedge
RESET  in  1  synchronous, active-high reset
DIN  in  8  message byte
DIN_VALID  in  1  DIN holds a valid byte
DIN_LAST  in  1  qualifies DIN as the final byte of the message
DIN_READY  out  1  the padder accepts a byte this cycle
W_OUT  out  32  message word, big-endian (first byte in bits [31:24])
I  out  6  word index within the block, 0..15; bits [5:4] always 0
W_VALID  out  1  W_OUT and I are valid
W_READY  in  1  the consumer accepts the word this cycle
FIRST  out  1  high with word 0 of the first block of a message
FINAL  out  1  high with word 15 of the last block of a message
DONE  out  1  one-cycle pulse on the cycle after the FINAL word transfers

Behaviour:
- Reset values (synchronous): W_OUT=0, I=0, W_VALID=0, FIRST=0, FINAL=0, DONE=0; byte_cnt=0; byte position p=0; state=COLLECT; DIN_READY=1 on the cycle after reset.
- Reset mid-operation: the message is abandoned. No partial or pad words are emitted, and the next byte starts a new message with FIRST set.
- Handshakes:
  - A byte transfers when DIN_VALID & DIN_READY at posedge.
  - A word transfers when W_VALID & W_READY at posedge.
  - W_OUT, I, FIRST and FINAL hold stable while W_VALID=1 and W_READY=0.
  - DIN_READY=1 only when state=COLLECT and W_VALID=0.
- COLLECT:
  - Each accepted byte is shifted into the word buffer at position p (p=0 → bits [31:24]); p increments and byte_cnt increments.
  - On the 4th byte with DIN_LAST=0: the word is registered, W_VALID rises on the next cycle, p resets to 0, next state is EMIT_DATA.
  - On DIN_LAST=1 at position p:
    - bytes p+1..3 are filled as 0x80 followed by zeros;
    - the word is emitted;
    - if p<3 the marker is inside this word and the next state is ZERO/LEN;
    - if p=3 the next state is EMIT_MARK.
- EMIT_DATA: on transfer, I increments (15 wraps to 0) and the state returns to COLLECT. Output latency from the 4th byte accepted to W_VALID is 1 cycle.
- EMIT_MARK: emits 0x80000000 at the current I, then proceeds to ZERO/LEN.
- Marker-index rule:
  - If the word holding the 0x80 marker has I=14 or I=15, flag extra=1.
  - ZERO emits 0x00000000 words until extra=0 and I=14. extra clears when I wraps 15→0.
  - If the marker word has I≤13, extra=0, and ZERO emits words until I=14. If the marker word is at I=13, ZERO emits no words.
- LEN_HI emits the high 32 bits of the 64-bit bit length at I=14. LEN_LO emits the low 32 bits at I=15 with FINAL=1.
- After the FINAL transfer: DONE=1 for 1 cycle; state=COLLECT; I=0; byte_cnt=0; p=0; the next message's word 0 carries FIRST=1.
- FIRST is set for I=0 of the first block only; it is 0 on all later blocks.
- A zero-length message is not supported: every message contains at least one byte with DIN_LAST.
- Bytes are never accepted while any pad, zero or length word is pending. DIN_READY stays low from DIN_LAST acceptance until DONE.
- If byte_cnt reaches 2^CNT_W-1, further bytes that are not DIN_LAST are undefined. The bench must not drive this case.

Test Plan:
- "abc" (0x61,0x62,0x63, LAST on 0x63), W_READY=1 → 16 words: I0=0x61626380 with FIRST, I1..I14=0, I15=0x00000018 with FINAL; DONE on the next cycle.
- "abcd" (LAST on 0x64) → I0=0x61626364, I1=0x80000000, I2..I14=0, I15=0x00000020.
- 55 bytes of 0x00 → single block: I13=0x00000080, I14=0, I15=0x000001B8.
- 56 bytes of 0x00 → two blocks:
  - block 1: I13=0, I14=0x80000000, I15=0;
  - block 2: I0..I13=0, FIRST=0 on I0, I14=0, I15=0x000001C0 with FINAL.
- Backpressure: hold W_READY=0 for 5 cycles on the first word of "abcd" → W_OUT=0x61626364 and I=0 stay stable, DIN_READY=0 throughout, and no byte is lost after release.
- Assert RESET for 1 cycle after 2 bytes of a message, then send "abc" → output is identical to the first scenario with no residue from the aborted message.
